// File: rtl/whitestar_mbox_pkg.sv
// Shared constants, access classification and the bus decode helper for the
// whitestar 6809 <-> display/sound mailbox.
package whitestar_mbox_pkg;

    localparam logic [1:0] REG_DATA = 2'b00;
    localparam logic [1:0] REG_RX   = 2'b01;
    localparam logic [1:0] REG_STAT = 2'b11;

    localparam int STAT_FULL    = 7;
    localparam int STAT_RX_FULL = 6;
    localparam int STAT_OVF     = 5;
    localparam int STAT_IRQ_EN  = 0;

    typedef enum logic [2:0] {
        ACC_NONE = 3'd0,
        ACC_PUSH = 3'd1,
        ACC_POP  = 3'd2,
        ACC_STAT = 3'd3,
        ACC_CTRL = 3'd4
    } acc_t;

    // Classify a bus access from the window bits, register offset and R/W.
    function automatic acc_t decode_acc(input logic [2:0] ba_hi, input logic [2:0] base,
                                        input logic [1:0] reg_off, input logic rd);
        acc_t acc;
        acc = ACC_NONE;
        if (ba_hi == base) begin
            case ({reg_off, rd})
                {REG_DATA, 1'b0}: acc = ACC_PUSH;
                {REG_RX,   1'b1}: acc = ACC_POP;
                {REG_STAT, 1'b1}: acc = ACC_STAT;
                {REG_STAT, 1'b0}: acc = ACC_CTRL;
                default:          acc = ACC_NONE;
            endcase
        end else begin
            acc = ACC_NONE;
        end
        return acc;
    endfunction

endpackage

// File: rtl/whitestar_mbox_fifo.sv
// Synchronous outbound FIFO; a push while full is accepted only when a pop
// frees a slot in the same cycle.
module whitestar_mbox_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == {CW{1'b0}});
    assign full      = (count_r == CNT_FULL);
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign rd_data   = mem_r[rd_ptr_r];

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/whitestar_mbox_ctrl.sv
// Clocked mailbox controller between the 6809 bus and the display/sound link.
// Define WHITESTAR_MBOX_FIRQ_EN to enable the CTRL register and FIRQ output.
module whitestar_mbox_ctrl
    import whitestar_mbox_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [2:0] BASE  = 3'b001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        e,
    input  logic        brw,
    input  logic [15:0] ba,
    input  logic [7:0]  bdi,
    output logic [7:0]  bdo,
    output logic        bdoe,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        firq_n,
    output logic        busy
);

    logic       e_meta_r, es_r, es_d_r;
    acc_t       cap_acc_r;
    logic [7:0] cap_bdi_r;
    logic [7:0] rx_hold_r;
    logic       rx_full_r, ovf_r;
    logic       irq_en_s;
    logic       commit_s;
    acc_t       acc_s, live_acc_s;
    logic       fifo_full_s, fifo_empty_s, tx_pop_s, push_s, ovf_set_s;
    logic [7:0] status_s, rd_mux_s;
    logic       unused_ba_s;

    assign unused_ba_s = ^{ba[12:3], ba[0]};

    // E synchroniser; es_d_r is kept only to find the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_meta_r <= 1'b0;
            es_r     <= 1'b0;
            es_d_r   <= 1'b0;
        end else begin
            e_meta_r <= e;
            es_r     <= e_meta_r;
            es_d_r   <= es_r;
        end
    end

    // Bus sampling while E is high; the last sample is what commits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_acc_r <= ACC_NONE;
            cap_bdi_r <= 8'h00;
        end else if (es_r) begin
            cap_acc_r <= decode_acc(ba[15:13], BASE, ba[2:1], brw);
            cap_bdi_r <= bdi;
        end
    end

    assign commit_s   = es_d_r & ~es_r;
    assign acc_s      = commit_s ? cap_acc_r : ACC_NONE;
    assign live_acc_s = decode_acc(ba[15:13], BASE, ba[2:1], brw);
    assign tx_pop_s   = tx_ready & ~fifo_empty_s;
    assign push_s     = (acc_s == ACC_PUSH);
    assign ovf_set_s  = push_s & fifo_full_s & ~tx_pop_s;

    whitestar_mbox_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (cap_bdi_r),
        .pop       (tx_ready),
        .rd_data   (tx_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // RX holding register and sticky overflow; overflow set beats clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold_r <= 8'h00;
            rx_full_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            if (rx_valid && !rx_full_r) begin
                rx_hold_r <= rx_data;
                rx_full_r <= 1'b1;
            end else if (acc_s == ACC_POP) begin
                rx_full_r <= 1'b0;
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (acc_s == ACC_STAT) begin
                ovf_r <= 1'b0;
            end
        end
    end

`ifdef WHITESTAR_MBOX_FIRQ_EN
    logic irq_en_r;
    logic firq_n_r;

    // Interrupt enable and registered FIRQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_r <= 1'b0;
            firq_n_r <= 1'b1;
        end else begin
            if (acc_s == ACC_CTRL) begin
                irq_en_r <= cap_bdi_r[0];
            end
            firq_n_r <= ~(rx_full_r & irq_en_r);
        end
    end

    assign irq_en_s = irq_en_r;
    assign firq_n   = firq_n_r;
`else
    assign irq_en_s = 1'b0;
    assign firq_n   = 1'b1;
`endif

    // Read-data mux driven straight from the live bus while E is high
    always_comb begin
        status_s               = 8'h00;
        status_s[STAT_FULL]    = fifo_full_s;
        status_s[STAT_RX_FULL] = rx_full_r;
        status_s[STAT_OVF]     = ovf_r;
        status_s[STAT_IRQ_EN]  = irq_en_s;
        case (live_acc_s)
            ACC_POP:  rd_mux_s = rx_hold_r;
            ACC_STAT: rd_mux_s = status_s;
            default:  rd_mux_s = 8'h00;
        endcase
    end

    assign bdoe     = es_r & ((live_acc_s == ACC_POP) | (live_acc_s == ACC_STAT));
    assign bdo      = bdoe ? rd_mux_s : 8'h00;
    assign tx_valid = ~fifo_empty_s;
    assign rx_ready = ~rx_full_r;
    assign busy     = fifo_full_s;

endmodule

// File: tb/tb_whitestar_mbox_ctrl.sv
// Directed bench for whitestar_mbox_ctrl with a queue-based mailbox model
// checked every cycle, plus literal expectations from the mailbox test plan.
module tb_whitestar_mbox_ctrl;

    localparam int DEPTH = 4;
`ifdef WHITESTAR_MBOX_FIRQ_EN
    localparam bit FIRQ_ON = 1'b1;
`else
    localparam bit FIRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, e, brw, tx_ready, rx_valid;
    logic [15:0] ba;
    logic [7:0]  bdi, rx_data;
    logic [7:0]  bdo, tx_data;
    logic        bdoe, tx_valid, rx_ready, firq_n, busy;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] m_q[$];
    logic       m_rx_full = 1'b0;
    logic [7:0] m_rx_hold = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_irq = 1'b0;
    logic       m_firq_n = 1'b1;
    logic [2:0] m_hist = 3'b000;
    logic       m_es = 1'b0;
    logic [7:0] tx_log[$];

    whitestar_mbox_ctrl #(.DEPTH(DEPTH), .BASE(3'b001)) dut (
        .clk(clk), .rst_n(rst_n), .e(e), .brw(brw), .ba(ba), .bdi(bdi),
        .bdo(bdo), .bdoe(bdoe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .firq_n(firq_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%02h exp=%02h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
        end
    endtask

    // 0 none, 1 push, 2 rx read, 3 status read, 4 ctrl write
    function automatic int m_dec(input logic [15:0] a, input logic rw);
        int off;
        off = (int'(a) >> 1) % 4;
        if (a < 16'h2000 || a > 16'h3FFF) return 0;
        if (!rw && off == 0) return 1;
        if (rw && off == 1) return 2;
        if (rw && off == 3) return 3;
        if (!rw && off == 3) return 4;
        return 0;
    endfunction

    function automatic logic [7:0] m_status();
        return {(m_q.size() == DEPTH), m_rx_full, m_ovf, 4'b0000, m_irq};
    endfunction

    // Model: advances once per clock, or clears on reset
    initial forever begin
        logic commit, pop, cap, was_full;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_q.delete();
            m_rx_full = 1'b0; m_rx_hold = 8'h00; m_ovf = 1'b0; m_irq = 1'b0;
            m_firq_n = 1'b1; m_hist = 3'b000; m_es = 1'b0;
        end else begin
            commit   = m_hist[2] & ~m_hist[1];
            was_full = (m_q.size() == DEPTH);
            pop      = (m_q.size() != 0) && tx_ready;
            cap      = rx_valid && !m_rx_full;
            m_firq_n = FIRQ_ON ? !(m_rx_full && m_irq) : 1'b1;
            if (pop) void'(m_q.pop_front());
            if (commit) begin
                case (m_dec(ba, brw))
                    1: if (!was_full || pop) m_q.push_back(bdi); else m_ovf = 1'b1;
                    2: if (m_rx_full) m_rx_full = 1'b0;
                    3: m_ovf = 1'b0;
                    4: if (FIRQ_ON) m_irq = bdi[0];
                    default: ;
                endcase
            end
            if (cap) begin
                m_rx_hold = rx_data;
                m_rx_full = 1'b1;
            end
            m_hist = {m_hist[1:0], e};
            m_es   = m_hist[1];
        end
    end

    // Compare process: every falling edge, DUT against model
    initial forever begin
        int         k;
        logic [7:0] exp_bdo;
        @(negedge clk);
        k = m_dec(ba, brw);
        exp_bdo = 8'h00;
        if (m_es && k == 2) exp_bdo = m_rx_hold;
        if (m_es && k == 3) exp_bdo = m_status();
        chk1("tx_valid", tx_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk8("tx_data", tx_data, m_q[0]);
        chk1("busy", busy, m_q.size() == DEPTH);
        chk1("rx_ready", rx_ready, !m_rx_full);
        chk1("firq_n", firq_n, m_firq_n);
        chk1("bdoe", bdoe, m_es && (k == 2 || k == 3));
        chk8("bdo", bdo, exp_bdo);
        if (rst_n && tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    // One full E cycle; optional literal check of read data mid-cycle
    task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d,
                             input bit chk, input logic [7:0] exp, input string nm);
        @(posedge clk); #2;
        ba = a; brw = rw; bdi = d; e = 1'b1;
        repeat (4) @(posedge clk);
        if (chk) begin
            @(negedge clk);
            chk1({nm, "_oe"}, bdoe, 1'b1);
            chk8(nm, bdo, exp);
        end
        @(posedge clk); #2;
        e = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        ba = 16'h0000; brw = 1'b1; bdi = 8'h00;
    endtask

    task automatic rx_send(input logic [7:0] d);
        @(posedge clk); #2;
        rx_valid = 1'b1; rx_data = d;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk); #2;
        tx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_log [10];
        exp_log = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
        rst_n = 1'b1; e = 1'b0; brw = 1'b1; ba = 16'h0000; bdi = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk1("rst_rx_ready", rx_ready, 1'b1);
        chk1("rst_firq_n", firq_n, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        bus_cycle(16'h2006, 1'b1, 8'h00, 1'b1, 8'h00, "rst_status");

        // fill, overflow, sticky ovf clear
        bus_cycle(16'h2000, 1'b0, 8'h11, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'h22, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'h33, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'h44, 1'b0, 8'h00, "");
        @(negedge clk);
        chk1("busy_full", busy, 1'b1);
        bus_cycle(16'h2000, 1'b0, 8'h55, 1'b0, 8'h00, "");
        bus_cycle(16'h2006, 1'b1, 8'h00, 1'b1, 8'hA0, "stat_ovf");
        bus_cycle(16'h2006, 1'b1, 8'h00, 1'b1, 8'h80, "stat_ovf_clr");
        chk8("model_stat_80", m_status(), 8'h80);

        // drain, then 6 more bytes across the pointer wrap
        drain();
        @(negedge clk);
        chk1("drain_busy", busy, 1'b0);
        chk1("drain_tx_valid", tx_valid, 1'b0);
        bus_cycle(16'h2000, 1'b0, 8'hA1, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'hA2, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'hA3, 1'b0, 8'h00, "");
        drain();
        bus_cycle(16'h2000, 1'b0, 8'hB1, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'hB2, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'hB3, 1'b0, 8'h00, "");
        drain();
        chk8("tx_log_len", 8'(tx_log.size()), 8'd10);
        for (int i = 0; i < 10 && i < tx_log.size(); i++) begin
            chk8($sformatf("tx_log_%0d", i), tx_log[i], exp_log[i]);
        end

        // RX path with a second byte held off while full
        rx_send(8'h5A);
        @(negedge clk);
        chk1("rx_ready_full", rx_ready, 1'b0);
        bus_cycle(16'h2006, 1'b1, 8'h00, 1'b1, 8'h40, "stat_rx_full");
        @(posedge clk); #2;
        rx_valid = 1'b1; rx_data = 8'h6B;
        bus_cycle(16'h2002, 1'b1, 8'h00, 1'b1, 8'h5A, "rx_read_5a");
        rx_valid = 1'b0;
        bus_cycle(16'h2002, 1'b1, 8'h00, 1'b1, 8'h6B, "rx_read_6b");
        @(negedge clk);
        chk1("rx_ready_empty", rx_ready, 1'b1);
        bus_cycle(16'h2002, 1'b1, 8'h00, 1'b1, 8'h6B, "rx_read_stale");

        // FIRQ
        bus_cycle(16'h2006, 1'b0, 8'h01, 1'b0, 8'h00, "");
        rx_send(8'h77);
        repeat (2) @(negedge clk);
        chk1("firq_assert", firq_n, !FIRQ_ON);
        bus_cycle(16'h2002, 1'b1, 8'h00, 1'b1, 8'h77, "rx_read_77");
        @(negedge clk);
        chk1("firq_release", firq_n, 1'b1);
        bus_cycle(16'h2006, 1'b0, 8'h00, 1'b0, 8'h00, "");

        // reset mid-burst
        bus_cycle(16'h2000, 1'b0, 8'hC1, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'hC2, 1'b0, 8'h00, "");
        bus_cycle(16'h2000, 1'b0, 8'hC3, 1'b0, 8'h00, "");
        @(negedge clk);
        chk1("pre_rst_tx_valid", tx_valid, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_tx_valid", tx_valid, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        bus_cycle(16'h2006, 1'b1, 8'h00, 1'b1, 8'h00, "post_rst_status");
        @(negedge clk);
        chk1("post_rst_tx_valid", tx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/whitestar_mbox_ctrl.md
Name: whitestar_mbox_ctrl

Overview:
- Sequenced mailbox between the 6809 main CPU bus and the display/sound board link.
- CPU writes bytes into an outbound FIFO, which drains to the link over a valid/ready handshake.
- Inbound link bytes land in a holding register that the CPU reads; status readback and an optional FIRQ complete the block.
- Replaces the pure GAL decode with a clocked controller in the CPU board glue logic.

Parameters:
- DEPTH, 4, outbound FIFO entries; power of 2, range 2..16.
- BASE, 3'b001, BA[15:13] match value for the mailbox window (0x2000-0x3FFF).

Ports:
- CLK  in  1  system clock, at least 8x the E frequency.
- RST_N  in  1  asynchronous active-low reset.
- E  in  1  6809 E clock, asynchronous to CLK.
- BRW  in  1  CPU read/not-write.
- BA  in  16  CPU address.
- BDI  in  8  CPU write data.
- BDO  out  8  CPU read data.
- BDOE  out  1  read-data drive enable.
- TX_DATA  out  8  outbound byte.
- TX_VALID  out  1  outbound byte valid.
- TX_READY  in  1  link accepts byte.
- RX_DATA  in  8  inbound byte.
- RX_VALID  in  1  inbound byte valid.
- RX_READY  out  1  holding register empty.
- FIRQ_N  out  1  CPU fast interrupt, active low.
- BUSY  out  1  outbound FIFO full.

Behaviour:
- Interface: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset values: FIFO empty, rx_full=0, ovf=0, irq_en=0. Outputs: BDO=0x00, BDOE=0, TX_VALID=0, RX_READY=1, FIRQ_N=1, BUSY=0.
- E is synchronised by two flops to es.
- While es=1, BA, BRW and BDI are registered every CLK. An access commits on the es 1->0 edge, using the last registered values, with one commit per E cycle.
- Decode: sel = (BA[15:13]==BASE). Registers by BA[2:1]:
  - 00 write: push BDI.
  - 01 read: pop RX.
  - 11 read: STATUS.
  - 11 write: CTRL.
  - All other combinations are ignored.
- Read data path:
  - BDOE = es & sel & BRW & decoded read.
  - BDO is combinational from current state while BDOE is high; otherwise 0x00.
  - RX read returns the holding register.
  - STATUS = {full, rx_full, ovf, 4'b0, irq_en}.
- Push:
  - If not full, write the entry; it is visible on TX_DATA/TX_VALID the next CLK.
  - If full, drop the byte and set ovf.
  - Push and TX pop in the same CLK while full: both happen, the push is accepted, and ovf is unchanged.
- TX handshake:
  - Transfer when TX_VALID & TX_READY.
  - TX_DATA is stable while TX_VALID=1 and TX_READY=0.
  - Pointers wrap modulo DEPTH; a count of DEPTH+1 states is kept.
- BUSY = full, registered.
- RX path:
  - RX_READY = ~rx_full.
  - On RX_VALID & RX_READY, capture RX_DATA and set rx_full.
  - A commit of an RX read clears rx_full; RX_READY rises the following CLK.
  - RX read with rx_full=0 returns the stale value with no state change.
- STATUS read commit clears ovf. A push-overflow in the same CLK wins, so ovf stays 1.
- Latency: write commit to TX_VALID is 1 CLK; RX capture to STATUS bit6 is 1 CLK.
- Reset mid-operation discards the FIFO and the holding register. TX_VALID drops asynchronously.

Optional Feature:
- Macro: WHITESTAR_MBOX_FIRQ_EN.
- Defined:
  - CTRL write sets irq_en = BDI[0].
  - FIRQ_N is registered low when rx_full & irq_en.
  - It deasserts the CLK after the RX read commit or after an irq_en=0 write.
- Undefined:
  - FIRQ_N is tied 1.
  - CTRL writes are ignored.
  - STATUS bit0 reads 0.

Decomposition:
- Package whitestar_mbox_pkg holds:
  - Register offset constants: REG_DATA=2'b00, REG_RX=2'b01, REG_STAT=2'b11.
  - STATUS bit index constants.
  - An access-type enum {ACC_NONE, ACC_PUSH, ACC_POP, ACC_STAT, ACC_CTRL}.
- One sub-module: whitestar_mbox_fifo, a synchronous FIFO parameterised by DEPTH with push/pop/full/empty.
- Top level: E synchroniser, bus capture and decode, RX holding register, status and FIRQ logic.

Test Plan:
- After reset, read 0x2006 -> BDO=0x00, TX_VALID=0, RX_READY=1, FIRQ_N=1.
- Write 0x11,0x22,0x33,0x44 to 0x2000 with TX_READY=0 -> BUSY=1 after the 4th. A 5th write of 0x55 is dropped, and a status read returns 0xA0. The next status read returns 0x80.
- TX_READY=1 -> TX_DATA sequence 0x11,0x22,0x33,0x44, then TX_VALID=0 and BUSY=0. Repeat across a pointer wrap (6 more bytes) with order preserved.
- RX_VALID with 0x5A -> RX_READY=0 and STATUS bit6=1. Read 0x2002 -> BDO=0x5A, RX_READY=1 one CLK after the E fall. A second RX_VALID with 0x6B while full is held off until then.
- With WHITESTAR_MBOX_FIRQ_EN: write 0x01 to 0x2006, inject RX 0x77 -> FIRQ_N=0. Read 0x2002 -> FIRQ_N=1. Without the macro, FIRQ_N stays 1.
- Assert RST_N=0 mid-burst with 3 bytes queued -> TX_VALID=0 immediately. After release: empty FIFO, STATUS=0x00.
